bsg_mesh_wormhole_out_arbiter: RTL

Per-output-direction wormhole arbiter for the 2D mesh router. It selects one of the router's input directions (P, W, E, N, S) round-robin and holds the grant for a whole multi-flit packet. Flits move into a single-entry registered output stage toward the neighbour link. It replaces the per-flit crossbar grant so packets from different sources never interleave on one link.

---
 rtl/bsg_mesh_wormhole_out_arbiter_if.sv | 25 ++
 rtl/bsg_mesh_wormhole_out_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/bsg_mesh_wormhole_out_arbiter_if.sv
// Handshake bundle between the mesh router input directions and one output
// arbiter: per-input flit offers and dequeues, plus the registered output link.
interface bsg_mesh_wormhole_out_arbiter_if #(
  parameter int inputs_p = 5,
  parameter int width_p  = 8
);
  logic [inputs_p-1:0]              v_i;
  logic [inputs_p-1:0][width_p-1:0] data_i;
  logic [inputs_p-1:0]              yumi_o;
  logic                             v_o;
  logic [width_p-1:0]               data_o;
  logic                             ready_and_i;
  logic [inputs_p-1:0]              grant_o;
  logic                             locked_o;

  modport master (
    output v_i, data_i, ready_and_i,
    input  yumi_o, v_o, data_o, grant_o, locked_o
  );

  modport slave (
    input  v_i, data_i, ready_and_i,
    output yumi_o, v_o, data_o, grant_o, locked_o
  );
endinterface

// File: rtl/bsg_mesh_wormhole_out_arbiter.sv
// Round-robin wormhole arbiter for one mesh output direction: picks an input,
// holds it for the whole packet, and forwards flits through a one-entry register.
module bsg_mesh_wormhole_out_arbiter #(
  parameter int inputs_p    = 5,
  parameter int width_p     = 8,
  parameter int len_width_p = 2
) (
  input logic clk,
  input logic reset,
  bsg_mesh_wormhole_out_arbiter_if.slave bus
);
  localparam int ptr_w = $clog2(inputs_p);
  localparam logic [0:0] idle_s   = 1'b0;
  localparam logic [0:0] locked_s = 1'b1;

  logic [0:0]             state;
  logic [ptr_w-1:0]       ptr, owner, win, sel;
  logic [ptr_w:0]         idx;
  logic [len_width_p-1:0] remaining, hdr_len;
  logic                   found, can_load, load, v_r;
  logic [width_p-1:0]     data_r, flit;
  logic [inputs_p-1:0]    yumi, grant;

  function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] x);
    inc = (x == ptr_w'(inputs_p - 1)) ? '0 : x + 1'b1;
  endfunction

  // Rotating priority search starting at ptr; idx is one bit wider so the
  // modulo fold works for non-power-of-two input counts.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < inputs_p; k++) begin
      idx = {1'b0, ptr} + (ptr_w+1)'(k);
      if (idx >= (ptr_w+1)'(inputs_p)) idx = idx - (ptr_w+1)'(inputs_p);
      if (!found && bus.v_i[idx[ptr_w-1:0]]) begin
        found = 1'b1;
        win   = idx[ptr_w-1:0];
      end
    end
  end

  assign can_load = !v_r | bus.ready_and_i;
  assign sel      = (state == idle_s) ? win : owner;
  assign flit     = bus.data_i[sel];
  assign hdr_len  = flit[width_p-1 -: len_width_p];

  always_comb begin
    yumi = '0;
    if (!reset && can_load) begin
      if (state == idle_s) yumi[win] = found;
      else                 yumi[owner] = bus.v_i[owner];
    end
  end

  assign load = |yumi;

  always_comb begin
    grant = '0;
    if (state == locked_s) grant[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= idle_s;
      ptr       <= '0;
      owner     <= '0;
      remaining <= '0;
      v_r       <= 1'b0;
      data_r    <= '0;
    end else begin
      if (load) begin
        v_r    <= 1'b1;
        data_r <= flit;
      end else if (bus.ready_and_i) begin
        v_r <= 1'b0;
      end
      if (load && state == idle_s) begin
        if (hdr_len == '0) begin
          ptr <= inc(win);
        end else begin
          state     <= locked_s;
          owner     <= win;
          remaining <= hdr_len;
        end
      end else if (load && state == locked_s) begin
        remaining <= remaining - 1'b1;
        // Tail flit: release the link and advance fairness past the owner.
        if (remaining == len_width_p'(1)) begin
          state <= idle_s;
          ptr   <= inc(owner);
        end
      end
    end
  end

  assign bus.yumi_o   = yumi;
  assign bus.v_o      = v_r;
  assign bus.data_o   = data_r;
  assign bus.grant_o  = grant;
  assign bus.locked_o = (state == locked_s);
endmodule
